alu_station_scheduler: RTL and testbench
========================================

ALU_STATION_SCHEDULER -- requirements
Module: alu_station_scheduler

Interface
REQ-001 Parameter RS_NUM, default 4, number of ALU reservation stations served.
REQ-002 Parameter POS_W, default 4, reorder-buffer position width.
REQ-003 Parameter DATA_W, default 32, result width.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous pipeline flush (mispredict).
REQ-007 issue_valid  input  1  issue stage offers one ALU instruction.
REQ-008 issue_ready  output  1  some station free and not reserved.
REQ-009 issue_grant  output  RS_NUM  one-hot station select, combinational.
REQ-010 rs_busy  input  RS_NUM  per-station busy.
REQ-011 rs_done_valid  input  RS_NUM  per-station result pending, held until acked.
REQ-012 rs_done_pos  input  RS_NUM*POS_W  per-station position, station i at bits [i*POS_W +: POS_W].
REQ-013 rs_done_value  input  RS_NUM*DATA_W  per-station result, packed likewise.
REQ-014 rs_done_ack  output  RS_NUM  one-cycle one-hot pulse, result taken.
REQ-015 wb_valid, wb_position, wb_value  output  1/POS_W/DATA_W  registered writeback to reorder buffer.
REQ-016 wb_ready  input  1  reorder buffer accepts writeback this cycle.
REQ-017 issue_stall_cnt, wb_stall_cnt  output  32 each  performance counters (REQ-032).

Function
REQ-018 free[i] = !rs_busy[i] && !reserved[i]; issue_ready = |free.
REQ-019 issue_grant selects lowest-index free station when issue_valid && issue_ready && !flush; else all zero.
REQ-020 Granted station's reserved bit sets at that edge and clears unconditionally the following edge; station raises rs_busy within that cycle.
REQ-021 Output register states: EMPTY (wb_valid=0), FULL (wb_valid=1); FULL->EMPTY on wb_ready with no new winner; stays FULL with new data on wb_ready with winner.
REQ-022 Arbitration occurs when (EMPTY or wb_ready) and !flush: round-robin over rs_done_valid starting at last_grant+1 modulo RS_NUM.
REQ-023 Winner j: rs_done_ack[j]=1 same cycle (combinational), wb_position/wb_value load station j fields at edge, last_grant<=j.
REQ-024 Latency: done_valid in cycle N with idle output -> wb_valid in cycle N+1; back-to-back one result per cycle while wb_ready=1.
REQ-025 FULL && !wb_ready: output register holds stable, no ack issued.
REQ-026 flush: clears wb_valid, reserved mask; last_grant<=RS_NUM-1; no ack, no grant that cycle.
REQ-027 Simultaneous issue grant and done ack to same station allowed (independent paths).

Reset
REQ-028 reset low: wb_valid=0, wb_position=0, wb_value=0, reserved=0, last_grant=RS_NUM-1, counters=0.
REQ-029 reset asserted mid-transfer discards output register; no ack produced during reset.
REQ-030 issue_grant, issue_ready, rs_done_ack combinational from registered state; zero while reset low.

Configuration
REQ-031 Macro SCHED_PERF_CNT_EN selects counters.
REQ-032 Defined: issue_stall_cnt increments per cycle issue_valid && !issue_ready; wb_stall_cnt per cycle wb_valid && !wb_ready; saturate at 0xFFFFFFFF; cleared by reset only. Undefined: both outputs constant 0, no counter registers.

Verification
REQ-033 rs_busy=4'b0101, issue_valid=1 -> issue_grant=4'b0010; next cycle with rs_busy unchanged, grant=4'b1000 (bit1 reserved).
REQ-034 rs_busy=4'b1111, issue_valid=1 for 5 cycles -> issue_ready=0, grant=0, issue_stall_cnt=5 (macro on) / 0 (off).
REQ-035 All four done_valid together, wb_ready=1 -> acks 0,1,2,3 on consecutive cycles; wb_position follows each station's pos one cycle later.
REQ-036 Station 2 done (pos=4'hA, value=32'h1234) with wb_ready=0 for 3 cycles -> wb_valid=1 stable, single ack, wb_stall_cnt=3.
REQ-037 flush while FULL with stations 1,3 pending -> wb_valid=0 next cycle, no ack that cycle; next arbitration grants station 1.
REQ-038 reset low mid-stream -> wb_valid=0 immediately (asynchronous), counters 0, after release first grant is lowest pending index.

Source files
------------

// File: rtl/alu_station_scheduler.sv
// ALU station scheduler: lowest-free-index issue allocation plus round-robin writeback arbitration.
// Defining SCHED_PERF_CNT_EN builds the saturating issue/writeback stall counters.
module alu_station_scheduler #(
    parameter int RS_NUM = 4,
    parameter int POS_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    output logic [RS_NUM-1:0]        issue_grant,
    input  logic [RS_NUM-1:0]        rs_busy,
    input  logic [RS_NUM-1:0]        rs_done_valid,
    input  logic [RS_NUM*POS_W-1:0]  rs_done_pos,
    input  logic [RS_NUM*DATA_W-1:0] rs_done_value,
    output logic [RS_NUM-1:0]        rs_done_ack,
    output logic                     wb_valid,
    output logic [POS_W-1:0]         wb_position,
    output logic [DATA_W-1:0]        wb_value,
    input  logic                     wb_ready,
    output logic [31:0]              issue_stall_cnt,
    output logic [31:0]              wb_stall_cnt
);
    localparam int IDX_W = (RS_NUM > 1) ? $clog2(RS_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RS_NUM - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} wb_state_t;

    wb_state_t         state_q, state_d;
    logic [RS_NUM-1:0] reserved_q;
    logic [RS_NUM-1:0] free;
    logic [IDX_W-1:0]  last_grant_q, last_grant_d;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W:0]    cand;
    logic              win_found;
    logic              arb_en;
    logic [POS_W-1:0]  wb_position_d;
    logic [DATA_W-1:0] wb_value_d;

    logic [POS_W-1:0]  pos_arr [RS_NUM];
    logic [DATA_W-1:0] val_arr [RS_NUM];

    for (genvar g = 0; g < RS_NUM; g++) begin : g_unpack
        assign pos_arr[g] = rs_done_pos[g*POS_W +: POS_W];
        assign val_arr[g] = rs_done_value[g*DATA_W +: DATA_W];
    end

    assign free        = ~rs_busy & ~reserved_q;
    assign issue_ready = reset & (|free);
    // free & -free isolates the lowest set bit, i.e. the lowest-index free station.
    assign issue_grant = (issue_valid && issue_ready && !flush) ? (free & (~free + RS_NUM'(1))) : '0;
    assign wb_valid    = (state_q == FULL);

    // NOTE: every signal in this block gets a default first, so no path can infer a latch.
    always_comb begin
        win_found     = 1'b0;
        win_idx       = '0;
        cand          = '0;
        rs_done_ack   = '0;
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wb_position_d = wb_position;
        wb_value_d    = wb_value;
        arb_en        = reset && !flush && (state_q == EMPTY || wb_ready);

        // Round-robin scan starting one past the previous winner, wrapping at RS_NUM.
        for (int k = 1; k <= RS_NUM; k++) begin
            cand = {1'b0, last_grant_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(RS_NUM))
                cand = cand - (IDX_W+1)'(RS_NUM);
            if (!win_found && rs_done_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end

        if (flush) begin
            state_d      = EMPTY;
            last_grant_d = LAST_IDX;
        end else if (arb_en) begin
            if (win_found) begin
                rs_done_ack[win_idx] = 1'b1;
                state_d              = FULL;
                last_grant_d         = win_idx;
                wb_position_d        = pos_arr[win_idx];
                wb_value_d           = val_arr[win_idx];
            end else begin
                state_d = EMPTY;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= EMPTY;
            reserved_q   <= '0;
            last_grant_q <= LAST_IDX;
            wb_position  <= '0;
            wb_value     <= '0;
        end else begin
            state_q      <= state_d;
            // A reservation lives exactly one cycle; the station's own busy flag covers it afterwards.
            reserved_q   <= issue_grant;
            last_grant_q <= last_grant_d;
            wb_position  <= wb_position_d;
            wb_value     <= wb_value_d;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] issue_stall_q;
    logic [31:0] wb_stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_stall_q <= '0;
            wb_stall_q    <= '0;
        end else begin
            if (issue_valid && !issue_ready && issue_stall_q != '1)
                issue_stall_q <= issue_stall_q + 32'd1;
            if (wb_valid && !wb_ready && wb_stall_q != '1)
                wb_stall_q <= wb_stall_q + 32'd1;
        end
    end

    assign issue_stall_cnt = issue_stall_q;
    assign wb_stall_cnt    = wb_stall_q;
`else
    assign issue_stall_cnt = '0;
    assign wb_stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_alu_station_scheduler.sv
// Directed bench for alu_station_scheduler: issue allocation, round-robin writeback, stall, flush and reset.
module tb_alu_station_scheduler;
    localparam int RS_NUM = 4;
    localparam int POS_W  = 4;
    localparam int DATA_W = 32;

`ifdef SCHED_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [RS_NUM-1:0]        issue_grant;
    logic [RS_NUM-1:0]        rs_busy;
    logic [RS_NUM-1:0]        rs_done_valid;
    logic [RS_NUM*POS_W-1:0]  rs_done_pos;
    logic [RS_NUM*DATA_W-1:0] rs_done_value;
    logic [RS_NUM-1:0]        rs_done_ack;
    logic                     wb_valid;
    logic [POS_W-1:0]         wb_position;
    logic [DATA_W-1:0]        wb_value;
    logic                     wb_ready;
    logic [31:0]              issue_stall_cnt;
    logic [31:0]              wb_stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    alu_station_scheduler #(.RS_NUM(RS_NUM), .POS_W(POS_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_grant(issue_grant),
        .rs_busy(rs_busy), .rs_done_valid(rs_done_valid), .rs_done_pos(rs_done_pos),
        .rs_done_value(rs_done_value), .rs_done_ack(rs_done_ack),
        .wb_valid(wb_valid), .wb_position(wb_position), .wb_value(wb_value), .wb_ready(wb_ready),
        .issue_stall_cnt(issue_stall_cnt), .wb_stall_cnt(wb_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_done(input int idx, input logic [POS_W-1:0] pos, input logic [DATA_W-1:0] val);
        rs_done_pos[idx*POS_W +: POS_W]    = pos;
        rs_done_value[idx*DATA_W +: DATA_W] = val;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; issue_valid = 1'b0; rs_busy = '0;
        rs_done_valid = 4'b1111; rs_done_pos = '0; rs_done_value = '0; wb_ready = 1'b1;
        #2;
        // Reset state: registers cleared, combinational outputs held at zero.
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_position", 32'(wb_position), 32'd0);
        check("rst_wb_value", wb_value, 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd0);
        check("rst_ack", 32'(rs_done_ack), 32'd0);
        check("rst_issue_cnt", issue_stall_cnt, 32'd0);
        rs_done_valid = '0;
        tick(); tick();
        reset = 1'b1;

        // Lowest free station, then reservation masks it for one cycle only.
        rs_busy = 4'b0101; issue_valid = 1'b1; #1;
        check("issue_ready", 32'(issue_ready), 32'd1);
        check("grant_first", 32'(issue_grant), 32'b0010);
        tick();
        check("grant_reserved", 32'(issue_grant), 32'b1000);
        tick();
        check("grant_res_clear", 32'(issue_grant), 32'b0010);
        issue_valid = 1'b0; #1;
        check("grant_idle", 32'(issue_grant), 32'd0);
        tick();

        // All stations busy for five cycles.
        rs_busy = 4'b1111; issue_valid = 1'b1; #1;
        check("full_ready", 32'(issue_ready), 32'd0);
        check("full_grant", 32'(issue_grant), 32'd0);
        repeat (5) tick();
        check("issue_stall_cnt", issue_stall_cnt, CNT_ON ? 32'd5 : 32'd0);
        issue_valid = 1'b0; rs_busy = '0;

        // All four pending with wb_ready high: acks in order, one per cycle.
        for (int i = 0; i < RS_NUM; i++) set_done(i, POS_W'(i + 1), 32'hA0 + 32'(i));
        rs_done_valid = 4'b1111; wb_ready = 1'b1; #1;
        check("rr_ack0", 32'(rs_done_ack), 32'b0001);
        tick(); rs_done_valid = 4'b1110; #1;
        check("rr_ack1", 32'(rs_done_ack), 32'b0010);
        check("rr_pos0", 32'(wb_position), 32'h1);
        check("rr_val0", wb_value, 32'hA0);
        tick(); rs_done_valid = 4'b1100; #1;
        check("rr_ack2", 32'(rs_done_ack), 32'b0100);
        check("rr_pos1", 32'(wb_position), 32'h2);
        tick(); rs_done_valid = 4'b1000; #1;
        check("rr_ack3", 32'(rs_done_ack), 32'b1000);
        check("rr_pos2", 32'(wb_position), 32'h3);
        tick(); rs_done_valid = 4'b0000; #1;
        check("rr_ack_none", 32'(rs_done_ack), 32'd0);
        check("rr_pos3", 32'(wb_position), 32'h4);
        check("rr_valid3", 32'(wb_valid), 32'd1);
        tick();
        check("rr_drain", 32'(wb_valid), 32'd0);

        // Station 2 result held through three stalled cycles.
        set_done(2, 4'hA, 32'h1234);
        rs_done_valid = 4'b0100; wb_ready = 1'b0; #1;
        check("stall_ack", 32'(rs_done_ack), 32'b0100);
        tick();
        set_done(0, 4'h5, 32'h55);
        rs_done_valid = 4'b0001; #1;
        check("stall_valid", 32'(wb_valid), 32'd1);
        check("stall_noack", 32'(rs_done_ack), 32'd0);
        repeat (3) tick();
        check("stall_hold_valid", 32'(wb_valid), 32'd1);
        check("stall_hold_pos", 32'(wb_position), 32'hA);
        check("stall_hold_val", wb_value, 32'h1234);
        check("stall_hold_noack", 32'(rs_done_ack), 32'd0);
        check("wb_stall_cnt", wb_stall_cnt, CNT_ON ? 32'd3 : 32'd0);
        wb_ready = 1'b1; #1;
        check("stall_release_ack", 32'(rs_done_ack), 32'b0001);
        tick(); rs_done_valid = '0; #1;
        check("stall_next_pos", 32'(wb_position), 32'h5);
        tick();

        // Flush while FULL (last winner station 1) with stations 1 and 3 pending.
        set_done(1, 4'h6, 32'h66);
        rs_done_valid = 4'b0010; #1;
        check("pre_flush_ack", 32'(rs_done_ack), 32'b0010);
        tick();
        set_done(1, 4'h7, 32'h77);
        set_done(3, 4'h8, 32'h88);
        rs_done_valid = 4'b1010; flush = 1'b1; issue_valid = 1'b1; #1;
        check("flush_noack", 32'(rs_done_ack), 32'd0);
        check("flush_nogrant", 32'(issue_grant), 32'd0);
        tick(); flush = 1'b0; issue_valid = 1'b0; #1;
        check("flush_clear", 32'(wb_valid), 32'd0);
        check("flush_rr_restart", 32'(rs_done_ack), 32'b0010);
        tick(); rs_done_valid = 4'b1000; #1;
        check("flush_pos1", 32'(wb_position), 32'h7);
        check("flush_ack3", 32'(rs_done_ack), 32'b1000);
        tick(); rs_done_valid = '0; #1;
        check("flush_pos3", 32'(wb_value), 32'h88);
        tick();

        // Asynchronous reset mid-stream.
        set_done(1, 4'h9, 32'h99);
        set_done(2, 4'hB, 32'hBB);
        rs_done_valid = 4'b0110; #1;
        check("mid_ack", 32'(rs_done_ack), 32'b0010);
        tick();
        check("mid_loaded", 32'(wb_position), 32'h9);
        reset = 1'b0; #1;
        check("arst_valid", 32'(wb_valid), 32'd0);
        check("arst_pos", 32'(wb_position), 32'd0);
        check("arst_val", wb_value, 32'd0);
        check("arst_noack", 32'(rs_done_ack), 32'd0);
        check("arst_issue_cnt", issue_stall_cnt, 32'd0);
        check("arst_wb_cnt", wb_stall_cnt, 32'd0);
        set_done(0, 4'hC, 32'hCC);
        set_done(3, 4'hD, 32'hDD);
        rs_done_valid = 4'b1001;
        tick();
        check("arst_hold_noack", 32'(rs_done_ack), 32'd0);
        reset = 1'b1; #1;
        check("post_rst_ack", 32'(rs_done_ack), 32'b0001);
        tick();
        check("post_rst_pos", 32'(wb_position), 32'hC);
        check("post_rst_val", wb_value, 32'hCC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
